sched_stat_decoder: RTL and testbench

- Receive end of the 3-bit phase-status bus (`clk_stat`) driven by the four-phase instruction scheduler (fetch, execute, memory, writeback).
- Decode the encoded status back into one-hot phase strobes for debug and display logic.
- Check that the phase sequence is legal, count completed instructions, and report sequence errors with a sticky flag and code.
- Sits beside the CPU core on the debug/monitor side; samples on the rising clock edge. The scheduler updates on the falling edge, so `clk_stat` is stable at the rising edge.

---
 rtl/sched_stat_decoder.sv | 196 +++++++++++++++++++
 tb/tb_sched_stat_decoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sched_stat_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sched_stat_decoder
//
// Receive side of the 3-bit phase-status bus driven by the four-phase
// instruction scheduler (fetch, execute, memory, writeback). The bus is
// sampled on the rising edge (the scheduler launches on the falling edge).
// The block:
//   - decodes the registered status into one-hot phase strobes,
//   - checks that the phase sequence is legal and classifies the first error,
//   - counts completed instructions (WB -> F transitions) and errors.
//
// Parameters
//   CNT_W      width of instr_cnt
//   ALLOW_HOLD 1 = a phase may repeat on consecutive samples (wait states)
//   MAX_HOLD   max extra consecutive samples of one phase (1..255)
//
// Ports
//   clk        in   system clock, all state updates on posedge
//   reset      in   asynchronous, active-high reset
//   clk_stat   in   phase status: 000=F 001=E 010=M 011=WB, bit2=1 illegal
//   err_clr    in   synchronous clear of seq_err / err_code
//   phf..phwb  out  phase strobes decoded from the registered status
//   seq_err    out  sticky error flag
//   err_code   out  code of the first error since the last clear
//   instr_cnt  out  completed instructions, wraps
//   err_cnt    out  total errors detected, saturates at 255
// ---------------------------------------------------------------------------
module sched_stat_decoder #(
   parameter int CNT_W      = 16,
   parameter bit ALLOW_HOLD = 1'b0,
   parameter int MAX_HOLD   = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       clk_stat,
   input  logic             err_clr,
   output logic             phf,
   output logic             phe,
   output logic             phm,
   output logic             phwb,
   output logic             seq_err,
   output logic [2:0]       err_code,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [7:0]       err_cnt
);

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_ILLEGAL  = 3'd1,
      ERR_BADSEQ   = 3'd2,
      ERR_BADSTART = 3'd3,
      ERR_HOLDTO   = 3'd4
   } err_code_e;

   localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
   localparam logic [2:0] PH_F       = 3'b000;
   localparam logic [2:0] PH_WB      = 3'b011;

   // State registers
   logic [2:0]       stat_q,      stat_d;
   logic             valid_q,     valid_d;
   logic [7:0]       hold_cnt_q,  hold_cnt_d;
   logic             seq_err_q,   seq_err_d;
   logic [2:0]       err_code_q,  err_code_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
   logic [7:0]       err_cnt_q,   err_cnt_d;

   // Classification of the incoming sample against the previous one
   logic [2:0] succ;
   logic       is_repeat;
   logic       is_succ;
   logic       hold_ok;
   logic       err_hit;
   logic       instr_inc;
   err_code_e  err_det;

   // -------------------------------------------------------------------------
   // Sequence check. A previous illegal code has no defined successor; the
   // only accepted recovery is a fresh fetch (000).
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first so no path can
      // leave it unassigned, which would otherwise infer a latch.
      succ      = 3'b000;
      is_repeat = 1'b0;
      is_succ   = 1'b0;
      hold_ok   = 1'b0;
      err_det   = ERR_NONE;

      if (!stat_q[2]) begin
         succ = {1'b0, stat_q[1:0] + 2'd1};
      end
      is_repeat = (clk_stat == stat_q);
      is_succ   = (clk_stat == succ);
      hold_ok   = ALLOW_HOLD && is_repeat;

      // Priority: ILLEGAL > BADSTART > BADSEQ > HOLDTO
      if (clk_stat[2]) begin
         err_det = ERR_ILLEGAL;
      end else if (!valid_q) begin
         if (clk_stat != PH_F) begin
            err_det = ERR_BADSTART;
         end
      end else if (!is_succ && !hold_ok) begin
         err_det = ERR_BADSEQ;
      end else if (hold_ok && (hold_cnt_q == MAX_HOLD_C)) begin
         err_det = ERR_HOLDTO;
      end
   end

   assign err_hit   = (err_det != ERR_NONE);
   assign instr_inc = valid_q && (stat_q == PH_WB) && (clk_stat == PH_F);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      stat_d      = clk_stat;
      valid_d     = 1'b1;
      hold_cnt_d  = 8'd0;
      seq_err_d   = seq_err_q;
      err_code_d  = err_code_q;
      instr_cnt_d = instr_cnt_q;
      err_cnt_d   = err_cnt_q;

      // Hold counter only runs on a genuine repeat of a sampled phase; the
      // reset value of stat_q is not a real sample.
      if (valid_q && hold_ok) begin
         hold_cnt_d = (hold_cnt_q == MAX_HOLD_C) ? hold_cnt_q : hold_cnt_q + 8'd1;
      end

      if (instr_inc) begin
         instr_cnt_d = instr_cnt_q + CNT_W'(1);
      end

      // A new error outranks a simultaneous clear; otherwise the first
      // error code since the last clear is kept.
      if (err_hit) begin
         seq_err_d = 1'b1;
         if (!seq_err_q || err_clr) begin
            err_code_d = err_det;
         end
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end else if (err_clr) begin
         seq_err_d  = 1'b0;
         err_code_d = ERR_NONE;
      end
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_q      <= 3'b000;
         valid_q     <= 1'b0;
         hold_cnt_q  <= 8'd0;
         seq_err_q   <= 1'b0;
         err_code_q  <= 3'd0;
         instr_cnt_q <= '0;
         err_cnt_q   <= 8'd0;
      end else begin
         stat_q      <= stat_d;
         valid_q     <= valid_d;
         hold_cnt_q  <= hold_cnt_d;
         seq_err_q   <= seq_err_d;
         err_code_q  <= err_code_d;
         instr_cnt_q <= instr_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from registers only, so there is no combinational path
   // from clk_stat. Illegal status or no sample yet gives all strobes low.
   // -------------------------------------------------------------------------
   assign phf       = valid_q && (stat_q == 3'b000);
   assign phe       = valid_q && (stat_q == 3'b001);
   assign phm       = valid_q && (stat_q == 3'b010);
   assign phwb      = valid_q && (stat_q == 3'b011);
   assign seq_err   = seq_err_q;
   assign err_code  = err_code_q;
   assign instr_cnt = instr_cnt_q;
   assign err_cnt   = err_cnt_q;

`ifndef SYNTHESIS
   strobe_onehot_a : assert property (@(posedge clk) disable iff (reset)
      $onehot0({phf, phe, phm, phwb}));
`endif

endmodule

// File: tb/tb_sched_stat_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sched_stat_decoder
//
// Two instances run on the same stimulus:
//   dut_a : CNT_W=4,  ALLOW_HOLD=0, MAX_HOLD=15
//   dut_b : CNT_W=16, ALLOW_HOLD=1, MAX_HOLD=3
// A behavioural model per instance is stepped on every rising edge and all
// outputs are compared on every falling edge. Directed scenarios add literal
// expectations, followed by a randomized phase stream.
// ---------------------------------------------------------------------------
module tb_sched_stat_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  clk_stat = 3'b000;
   logic        err_clr = 1'b0;

   logic        a_phf, a_phe, a_phm, a_phwb, a_seq_err;
   logic [2:0]  a_err_code;
   logic [3:0]  a_instr_cnt;
   logic [7:0]  a_err_cnt;

   logic        b_phf, b_phe, b_phm, b_phwb, b_seq_err;
   logic [2:0]  b_err_code;
   logic [15:0] b_instr_cnt;
   logic [7:0]  b_err_cnt;

   int errors = 0;
   int checks = 0;

   sched_stat_decoder #(.CNT_W(4), .ALLOW_HOLD(1'b0), .MAX_HOLD(15)) dut_a (
      .clk(clk), .reset(reset), .clk_stat(clk_stat), .err_clr(err_clr),
      .phf(a_phf), .phe(a_phe), .phm(a_phm), .phwb(a_phwb),
      .seq_err(a_seq_err), .err_code(a_err_code),
      .instr_cnt(a_instr_cnt), .err_cnt(a_err_cnt)
   );

   sched_stat_decoder #(.CNT_W(16), .ALLOW_HOLD(1'b1), .MAX_HOLD(3)) dut_b (
      .clk(clk), .reset(reset), .clk_stat(clk_stat), .err_clr(err_clr),
      .phf(b_phf), .phe(b_phe), .phm(b_phm), .phwb(b_phwb),
      .seq_err(b_seq_err), .err_code(b_err_code),
      .instr_cnt(b_instr_cnt), .err_cnt(b_err_cnt)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   typedef struct {
      logic [2:0] stat;
      bit         valid;
      int         hold;
      bit         seq_err;
      int         code;
      int         icnt;
      int         ecnt;
   } model_t;

   function automatic model_t model_reset();
      model_t r;
      r.stat = 3'b000; r.valid = 0; r.hold = 0; r.seq_err = 0;
      r.code = 0; r.icnt = 0; r.ecnt = 0;
      return r;
   endfunction

   // One sample of the phase bus applied to the model.
   function automatic model_t model_step(model_t m, logic [2:0] nw, bit clr,
                                         bit allow, int maxh, int cntw);
      model_t r;
      int     code;
      int     want;
      bit     rep;
      r    = m;
      code = 0;
      rep  = (nw == m.stat);
      if (nw[2]) code = 1;
      else if (!m.valid) code = (nw != 3'd0) ? 3 : 0;
      else begin
         want = m.stat[2] ? 0 : (int'(m.stat) + 1) % 4;
         if (int'(nw) == want) code = 0;
         else if (rep && allow) code = (m.hold == maxh) ? 4 : 0;
         else code = 2;
      end
      r.hold = (m.valid && rep && allow) ? ((m.hold < maxh) ? m.hold + 1 : maxh) : 0;
      if (m.valid && m.stat == 3'd3 && nw == 3'd0) r.icnt = (m.icnt + 1) % (1 << cntw);
      if (code != 0) begin
         r.seq_err = 1;
         if (!m.seq_err || clr) r.code = code;
         if (m.ecnt < 255) r.ecnt = m.ecnt + 1;
      end else if (clr) begin
         r.seq_err = 0;
         r.code    = 0;
      end
      r.stat  = nw;
      r.valid = 1;
      return r;
   endfunction

   model_t ma, mb;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ma <= model_reset();
         mb <= model_reset();
      end else begin
         ma <= model_step(ma, clk_stat, err_clr, 1'b0, 15, 4);
         mb <= model_step(mb, clk_stat, err_clr, 1'b1, 3, 16);
      end
   end

   // -------------------------------------------------------------- checking
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_dut(input string tag, input model_t m, input logic [3:0] strb,
                            input logic se, input logic [2:0] ec,
                            input logic [31:0] ic, input logic [7:0] en);
      logic [3:0] es;
      es = 4'b0000;
      if (m.valid && !m.stat[2]) es[3 - int'(m.stat[1:0])] = 1'b1;
      check({tag, ".strobes"},   32'(strb), 32'(es));
      check({tag, ".seq_err"},   32'(se),   32'(m.seq_err));
      check({tag, ".err_code"},  32'(ec),   32'(m.code));
      check({tag, ".instr_cnt"}, ic,        32'(m.icnt));
      check({tag, ".err_cnt"},   32'(en),   32'(m.ecnt));
   endtask

   always @(negedge clk) begin
      check_dut("a", ma, {a_phf, a_phe, a_phm, a_phwb}, a_seq_err, a_err_code,
                32'(a_instr_cnt), a_err_cnt);
      check_dut("b", mb, {b_phf, b_phe, b_phm, b_phwb}, b_seq_err, b_err_code,
                32'(b_instr_cnt), b_err_cnt);
   end

   // -------------------------------------------------------------- stimulus
   // Apply one sample; returns at the falling edge after it was captured.
   task automatic drive(input logic [2:0] s, input logic c);
      clk_stat = s;
      err_clr  = c;
      @(negedge clk);
   endtask

   // Asynchronous reset in the middle of the low phase; outputs must clear
   // without a clock edge. Returns at a falling edge with reset released.
   task automatic do_reset();
      #2 reset = 1'b1;
      clk_stat = 3'b110;
      err_clr  = 1'b0;
      #1;
      check("rst.a_strobes", 32'({a_phf, a_phe, a_phm, a_phwb}), 32'd0);
      check("rst.a_seq_err", 32'(a_seq_err), 32'd0);
      check("rst.a_err_code", 32'(a_err_code), 32'd0);
      check("rst.a_instr_cnt", 32'(a_instr_cnt), 32'd0);
      check("rst.a_err_cnt", 32'(a_err_cnt), 32'd0);
      check("rst.b_strobes", 32'({b_phf, b_phe, b_phm, b_phwb}), 32'd0);
      check("rst.b_seq_err", 32'(b_seq_err), 32'd0);
      check("rst.b_err_cnt", 32'(b_err_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [2:0] succ_of(logic [2:0] s);
      return s[2] ? 3'b000 : {1'b0, s[1:0] + 2'd1};
   endfunction

   logic [2:0] cur;
   logic [2:0] nxt;
   int         r;

   initial begin
      #1 reset = 1'b1;
      @(negedge clk);
      do_reset();

      // Scheduler rotation, 5 instructions; strobe follows stimulus by 1 clk.
      for (int rep = 0; rep < 5; rep++) begin
         for (int p = 0; p < 4; p++) begin
            drive(3'(p), 1'b0);
            check("rot.a_strobe", 32'({a_phf, a_phe, a_phm, a_phwb}), 32'(4'b1000 >> p));
         end
      end
      check("rot.a_instr_cnt", 32'(a_instr_cnt), 32'd4);
      check("rot.b_instr_cnt", 32'(b_instr_cnt), 32'd4);
      check("rot.a_seq_err", 32'(a_seq_err), 32'd0);
      check("rot.a_err_cnt", 32'(a_err_cnt), 32'd0);

      // BADSTART, then recovery and clear.
      do_reset();
      drive(3'b001, 1'b0);
      check("bs.a_seq_err", 32'(a_seq_err), 32'd1);
      check("bs.a_err_code", 32'(a_err_code), 32'd3);
      check("bs.b_err_cnt", 32'(b_err_cnt), 32'd1);
      drive(3'b010, 1'b0);
      drive(3'b011, 1'b0);
      drive(3'b000, 1'b1);
      check("clr.a_seq_err", 32'(a_seq_err), 32'd0);
      check("clr.a_err_code", 32'(a_err_code), 32'd0);
      check("clr.a_err_cnt", 32'(a_err_cnt), 32'd1);

      // Repeat is BADSEQ without holds; a later illegal keeps the first code.
      do_reset();
      drive(3'b000, 1'b0);
      drive(3'b001, 1'b0);
      drive(3'b001, 1'b0);
      check("rep.a_err_code", 32'(a_err_code), 32'd2);
      check("rep.b_seq_err", 32'(b_seq_err), 32'd0);
      drive(3'b010, 1'b0);
      drive(3'b100, 1'b0);
      check("ill.a_err_cnt", 32'(a_err_cnt), 32'd2);
      check("ill.a_err_code", 32'(a_err_code), 32'd2);
      check("ill.a_strobes", 32'({a_phf, a_phe, a_phm, a_phwb}), 32'd0);
      check("ill.b_err_code", 32'(b_err_code), 32'd1);
      drive(3'b000, 1'b0);
      check("resync.a_err_cnt", 32'(a_err_cnt), 32'd2);
      check("resync.a_phf", 32'(a_phf), 32'd1);

      // Hold limit MAX_HOLD=3 on dut_b.
      do_reset();
      drive(3'b000, 1'b0);
      drive(3'b001, 1'b0);
      repeat (4) drive(3'b010, 1'b0);
      drive(3'b011, 1'b0);
      check("hold4.b_seq_err", 32'(b_seq_err), 32'd0);
      check("hold4.b_err_cnt", 32'(b_err_cnt), 32'd0);
      drive(3'b000, 1'b0);
      drive(3'b001, 1'b0);
      repeat (4) drive(3'b010, 1'b0);
      check("hold4b.b_seq_err", 32'(b_seq_err), 32'd0);
      drive(3'b010, 1'b0);
      check("hold5.b_seq_err", 32'(b_seq_err), 32'd1);
      check("hold5.b_err_code", 32'(b_err_code), 32'd4);
      check("hold5.b_err_cnt", 32'(b_err_cnt), 32'd1);

      // Clear coincident with a new error: the new error wins.
      drive(3'b101, 1'b1);
      check("clrerr.b_seq_err", 32'(b_seq_err), 32'd1);
      check("clrerr.b_err_code", 32'(b_err_code), 32'd1);
      check("clrerr.a_err_code", 32'(a_err_code), 32'd1);

      // instr_cnt wrap on the 4-bit instance.
      do_reset();
      drive(3'b000, 1'b0);
      for (int n = 1; n <= 16; n++) begin
         drive(3'b001, 1'b0);
         drive(3'b010, 1'b0);
         drive(3'b011, 1'b0);
         drive(3'b000, 1'b0);
         if (n == 15) check("wrap15.a_instr_cnt", 32'(a_instr_cnt), 32'd15);
      end
      check("wrap.a_instr_cnt", 32'(a_instr_cnt), 32'd0);
      check("wrap.b_instr_cnt", 32'(b_instr_cnt), 32'd16);

      // Reset during M with an error pending, release with F.
      drive(3'b001, 1'b0);
      drive(3'b011, 1'b0);
      drive(3'b000, 1'b0);
      drive(3'b001, 1'b0);
      drive(3'b010, 1'b0);
      check("midm.a_seq_err", 32'(a_seq_err), 32'd1);
      check("midm.a_phm", 32'(a_phm), 32'd1);
      do_reset();
      drive(3'b000, 1'b0);
      check("rel.a_seq_err", 32'(a_seq_err), 32'd0);
      check("rel.a_phf", 32'(a_phf), 32'd1);
      check("rel.b_phf", 32'(b_phf), 32'd1);

      // err_cnt saturation.
      do_reset();
      repeat (300) drive(3'b111, 1'b0);
      check("sat.a_err_cnt", 32'(a_err_cnt), 32'd255);
      check("sat.b_err_cnt", 32'(b_err_cnt), 32'd255);

      // Randomized phase stream, mostly legal with repeats, jumps and resets.
      do_reset();
      cur = 3'b011;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
            cur = 3'b011;
         end else begin
            r = int'($urandom_range(0, 99));
            if (r < 65)      nxt = succ_of(cur);
            else if (r < 85) nxt = cur;
            else if (r < 95) nxt = 3'($urandom_range(0, 3));
            else             nxt = 3'($urandom_range(4, 7));
            drive(nxt, ($urandom_range(0, 19) == 0));
            cur = nxt;
         end
      end
      drive(3'b000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
